// File: rtl/gpio_cfg_pkg.sv
// Shared definitions for the GPIO pad-configuration sequencer: the field layout
// of one pad's configuration word, its reset value and the FSM state encoding.
package gpio_cfg_pkg;

  // One pad configuration word: {dm[2:0], ib_mode_sel, vtrip_sel, slow_sel, inp_dis}
  localparam int CFG_W       = 7;
  localparam int DM_MSB      = 6;
  localparam int DM_MID      = 5;
  localparam int DM_LSB      = 4;
  localparam int IB_MODE_SEL = 3;
  localparam int VTRIP_SEL   = 2;
  localparam int SLOW_SEL    = 1;
  localparam int INP_DIS     = 0;

  // dm=001 (input only), every other bit cleared
  localparam logic [CFG_W-1:0] CFG_RESET = 7'b001_0000;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_COMMIT = 1'b1
  } state_t;

endpackage

// File: rtl/gpio_cfg_regfile.sv
// Shadow and active configuration arrays for all pads. Shadow takes software
// writes, active is loaded one pad at a time from shadow and drives the pads.
module gpio_cfg_regfile
  import gpio_cfg_pkg::*;
#(
  parameter int NUM_PADS = 44,
  parameter int IDX_W    = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                shadow_we,
  input  logic [IDX_W-1:0]    shadow_addr,
  input  logic [CFG_W-1:0]    shadow_data,
  input  logic                active_we,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic [CFG_W-1:0]    shadow_rd,
  output logic [CFG_W-1:0]    active_rd,
  output logic [NUM_PADS-1:0] gpio_dm2,
  output logic [NUM_PADS-1:0] gpio_dm1,
  output logic [NUM_PADS-1:0] gpio_dm0,
  output logic [NUM_PADS-1:0] gpio_ib_mode_sel,
  output logic [NUM_PADS-1:0] gpio_vtrip_sel,
  output logic [NUM_PADS-1:0] gpio_slow_sel,
  output logic [NUM_PADS-1:0] gpio_inp_dis
);

  logic [CFG_W-1:0] shadow_q [NUM_PADS];
  logic [CFG_W-1:0] active_q [NUM_PADS];

  // Shadow array: software-visible staging copy, one write port
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_PADS; i++) shadow_q[i] <= CFG_RESET;
    end else if (shadow_we) begin
      shadow_q[shadow_addr] <= shadow_data;
    end
  end

  // Active array: loaded from shadow at the sequencer's copy edge for pad rd_idx
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_PADS; i++) active_q[i] <= CFG_RESET;
    end else if (active_we) begin
      active_q[rd_idx] <= shadow_q[rd_idx];
    end
  end

  assign shadow_rd = shadow_q[rd_idx];
  assign active_rd = active_q[rd_idx];

  // Unpack the active words into per-field pad vectors (pure wiring of flops)
  always_comb begin
    gpio_dm2         = '0;
    gpio_dm1         = '0;
    gpio_dm0         = '0;
    gpio_ib_mode_sel = '0;
    gpio_vtrip_sel   = '0;
    gpio_slow_sel    = '0;
    gpio_inp_dis     = '0;
    for (int i = 0; i < NUM_PADS; i++) begin
      gpio_dm2[i]         = active_q[i][DM_MSB];
      gpio_dm1[i]         = active_q[i][DM_MID];
      gpio_dm0[i]         = active_q[i][DM_LSB];
      gpio_ib_mode_sel[i] = active_q[i][IB_MODE_SEL];
      gpio_vtrip_sel[i]   = active_q[i][VTRIP_SEL];
      gpio_slow_sel[i]    = active_q[i][SLOW_SEL];
      gpio_inp_dis[i]     = active_q[i][INP_DIS];
    end
  end

endmodule

// File: rtl/gpio_pad_cfg_sequencer.sv
// Pad-configuration sequencer: accepts per-pad shadow writes and, on commit,
// walks all pads copying shadow to active so that no two pads ever change in
// the same cycle. Changed pads dwell STEP_CYCLES cycles, unchanged pads one.
//
// Handshake: a write transfers on a rising edge where cfg_valid && cfg_ready.
// cfg_ready is high exactly in IDLE; cfg_valid may be held while not ready and
// the request is taken on the first ready edge. No data path from cfg_* to pads.
module gpio_pad_cfg_sequencer
  import gpio_cfg_pkg::*;
#(
  parameter int NUM_PADS    = 44,
  parameter int STEP_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [5:0]          cfg_pad,
  input  logic [CFG_W-1:0]    cfg_data,
  input  logic                commit_req,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [NUM_PADS-1:0] gpio_dm2,
  output logic [NUM_PADS-1:0] gpio_dm1,
  output logic [NUM_PADS-1:0] gpio_dm0,
  output logic [NUM_PADS-1:0] gpio_ib_mode_sel,
  output logic [NUM_PADS-1:0] gpio_vtrip_sel,
  output logic [NUM_PADS-1:0] gpio_slow_sel,
  output logic [NUM_PADS-1:0] gpio_inp_dis
);

  localparam int IDX_W   = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;
  localparam int TIMER_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(STEP_CYCLES - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_PADS - 1);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                wr_fire, pad_in_range, pad_changed, copy_en;
  logic [CFG_W-1:0]    shadow_rd, active_rd;

  assign cfg_ready    = (state_q == ST_IDLE);
  assign busy         = (state_q == ST_COMMIT);
  assign done         = done_q;
  assign err          = err_q;
  assign wr_fire      = cfg_valid && cfg_ready;
  assign pad_in_range = 32'(cfg_pad) < NUM_PADS;
  assign pad_changed  = (shadow_rd != active_rd);
  assign err_d        = wr_fire && !pad_in_range;

  // State, walk index, dwell timer and the single-cycle status pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      timer_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next state: unchanged pads advance at once, changed pads copy on the last dwell cycle
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    copy_en = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (commit_req) begin
          state_d = ST_COMMIT;
          idx_d   = '0;
          timer_d = '0;
        end
      end
      ST_COMMIT: begin
        if (pad_changed && (timer_q != TIMER_LAST)) begin
          timer_d = timer_q + 1'b1;
        end else begin
          copy_en = pad_changed;
          timer_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  gpio_cfg_regfile #(
    .NUM_PADS (NUM_PADS),
    .IDX_W    (IDX_W)
  ) u_regfile (
    .clk              (clk),
    .reset            (reset),
    .shadow_we        (wr_fire && pad_in_range),
    .shadow_addr      (IDX_W'(cfg_pad)),
    .shadow_data      (cfg_data),
    .active_we        (copy_en),
    .rd_idx           (idx_q),
    .shadow_rd        (shadow_rd),
    .active_rd        (active_rd),
    .gpio_dm2         (gpio_dm2),
    .gpio_dm1         (gpio_dm1),
    .gpio_dm0         (gpio_dm0),
    .gpio_ib_mode_sel (gpio_ib_mode_sel),
    .gpio_vtrip_sel   (gpio_vtrip_sel),
    .gpio_slow_sel    (gpio_slow_sel),
    .gpio_inp_dis     (gpio_inp_dis)
  );

endmodule

// File: tb/tb_gpio_pad_cfg_sequencer.sv
// Bench for gpio_pad_cfg_sequencer: write vectors from a table, commit, and
// compare every observed pad-output change against an expected-change queue.
module tb_gpio_pad_cfg_sequencer;

  localparam int NP   = 44;
  localparam int STEP = 4;
  localparam int SW   = 7 * NP;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          cfg_valid, cfg_ready, commit_req, busy, done, err;
  logic [5:0]    cfg_pad;
  logic [6:0]    cfg_data;
  logic [NP-1:0] gpio_dm2, gpio_dm1, gpio_dm0, gpio_ib_mode_sel;
  logic [NP-1:0] gpio_vtrip_sel, gpio_slow_sel, gpio_inp_dis;
  logic [SW-1:0] dut_snap;

  assign dut_snap = {gpio_dm2, gpio_dm1, gpio_dm0, gpio_ib_mode_sel,
                     gpio_vtrip_sel, gpio_slow_sel, gpio_inp_dis};

  gpio_pad_cfg_sequencer #(.NUM_PADS(NP), .STEP_CYCLES(STEP)) dut (
    .clk              (clk),
    .reset            (reset),
    .cfg_valid        (cfg_valid),
    .cfg_ready        (cfg_ready),
    .cfg_pad          (cfg_pad),
    .cfg_data         (cfg_data),
    .commit_req       (commit_req),
    .busy             (busy),
    .done             (done),
    .err              (err),
    .gpio_dm2         (gpio_dm2),
    .gpio_dm1         (gpio_dm1),
    .gpio_dm0         (gpio_dm0),
    .gpio_ib_mode_sel (gpio_ib_mode_sel),
    .gpio_vtrip_sel   (gpio_vtrip_sel),
    .gpio_slow_sel    (gpio_slow_sel),
    .gpio_inp_dis     (gpio_inp_dis)
  );

  // ---------------- model and scoreboard ----------------
  logic [6:0]     sh_m  [NP];
  logic [6:0]     act_m [NP];
  logic [SW+15:0] exp_q [$];   // {cycle the change becomes visible, expected pad outputs}
  int total = 0;
  int bad   = 0;

  typedef struct {
    int         phase;
    logic [5:0] pad;
    logic [6:0] data;
    bit         exp_err;
  } vec_t;
  vec_t vecs [10];

  function automatic logic [SW-1:0] model_snap();
    logic [NP-1:0] d2, d1, d0, ib, vt, sl, ip;
    for (int i = 0; i < NP; i++) begin
      {d2[i], d1[i], d0[i], ib[i], vt[i], sl[i], ip[i]} = act_m[i];
    end
    return {d2, d1, d0, ib, vt, sl, ip};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      sh_m[i]  = 7'b001_0000;
      act_m[i] = 7'b001_0000;
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset      = 1'b1;
    cfg_valid  = 1'b0;
    commit_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic write_cfg(input logic [5:0] pad, input logic [6:0] data, input bit exp_err);
    @(negedge clk);
    check_int("wr_ready", int'(cfg_ready), 1);
    cfg_valid = 1'b1;
    cfg_pad   = pad;
    cfg_data  = data;
    @(negedge clk);
    cfg_valid = 1'b0;
    check_int("err_pulse", int'(err), int'(exp_err));
    check_vec("wr_no_out_change", dut_snap, model_snap());
    if (pad < NP) sh_m[pad] = data;
    @(negedge clk);
    check_int("err_one_cycle", int'(err), 0);
  endtask

  // Commit and monitor. Optional: a write on the same edge as commit_req, a
  // write held during the commit, and commit_req re-pulsed mid-commit.
  task automatic run_commit(input bit same_wr, input logic [5:0] wpad, input logic [6:0] wdata,
                            input bit hold_wr, input logic [5:0] hpad, input logic [6:0] hdata,
                            input bit mid_req);
    int t, done_at;
    bit bad_busy, ready_seen;
    logic [SW-1:0]  prev;
    logic [SW+15:0] e;
    @(negedge clk);
    commit_req = 1'b1;
    if (same_wr) begin
      cfg_valid = 1'b1;
      cfg_pad   = wpad;
      cfg_data  = wdata;
      if (wpad < NP) sh_m[wpad] = wdata;
    end
    t = 0;
    for (int p = 0; p < NP; p++) begin
      if (sh_m[p] !== act_m[p]) begin
        t += STEP;
        act_m[p] = sh_m[p];
        exp_q.push_back({16'(t), model_snap()});
      end else begin
        t += 1;
      end
    end
    prev = dut_snap;
    @(negedge clk);
    commit_req = 1'b0;
    cfg_valid  = 1'b0;
    if (hold_wr) begin
      cfg_valid = 1'b1;
      cfg_pad   = hpad;
      cfg_data  = hdata;
    end
    done_at = -1;
    bad_busy = 1'b0;
    ready_seen = 1'b0;
    for (int n = 0; n < 200 && done_at < 0; n++) begin
      if (n > 0) @(negedge clk);
      if (mid_req) commit_req = (n >= 10 && n < 13);
      if (dut_snap !== prev) begin
        if (exp_q.size() == 0) begin
          check_vec("unexpected_change", dut_snap, prev);
        end else begin
          e = exp_q.pop_front();
          check_int("change_cycle", n, int'(e[SW +: 16]));
          check_vec("change_value", dut_snap, e[SW-1:0]);
        end
        prev = dut_snap;
      end
      if (done) begin
        done_at = n;
      end else begin
        if (!busy) bad_busy = 1'b1;
        if (cfg_ready) ready_seen = 1'b1;
      end
    end
    commit_req = 1'b0;
    check_int("commit_len", done_at, t);
    check_int("busy_during", int'(bad_busy), 0);
    check_int("ready_during", int'(ready_seen), 0);
    check_int("events_left", exp_q.size(), 0);
    exp_q.delete();
    check_int("busy_at_done", int'(busy), 0);
    check_int("ready_at_done", int'(cfg_ready), 1);
    if (hold_wr && hpad < NP) sh_m[hpad] = hdata;
    @(negedge clk);
    cfg_valid = 1'b0;
    check_int("done_one_cycle", int'(done), 0);
    bad_busy = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (busy) bad_busy = 1'b1;
    end
    check_int("no_restart", int'(bad_busy), 0);
    check_vec("post_commit_pads", dut_snap, model_snap());
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit seen_done, seen_busy;
    reset      = 1'b1;
    cfg_valid  = 1'b0;
    cfg_pad    = '0;
    cfg_data   = '0;
    commit_req = 1'b0;

    vecs[0] = '{0, 6'd5,  7'b110_0001, 1'b0};
    vecs[1] = '{1, 6'd0,  7'b011_1010, 1'b0};
    vecs[2] = '{1, 6'd43, 7'b101_0110, 1'b0};
    vecs[3] = '{2, 6'd50, 7'b111_1111, 1'b1};
    vecs[4] = '{2, 6'd63, 7'b000_0001, 1'b1};
    vecs[5] = '{3, 6'd7,  7'b001_0000, 1'b0};
    vecs[6] = '{3, 6'($urandom_range(21, 42)), 7'($urandom_range(0, 127)), 1'b0};
    vecs[7] = '{3, 6'($urandom_range(21, 42)), 7'($urandom_range(0, 127)), 1'b0};
    vecs[8] = '{3, 6'd20, 7'b100_0100, 1'b0};
    vecs[9] = '{3, 6'd20, 7'b010_0101, 1'b0};

    do_reset();
    @(negedge clk);
    model_reset();
    check_vec("reset_pads", dut_snap, {{NP{1'b0}}, {NP{1'b0}}, {NP{1'b1}}, {(4*NP){1'b0}}});
    check_int("reset_ready", int'(cfg_ready), 1);
    check_int("reset_busy", int'(busy), 0);
    check_int("reset_done", int'(done), 0);
    check_int("reset_err", int'(err), 0);

    // Table phases: apply the writes of each phase, then commit
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 10; i++) begin
        if (vecs[i].phase == ph) write_cfg(vecs[i].pad, vecs[i].data, vecs[i].exp_err);
      end
      run_commit(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    end

    // Write on the same edge as commit_req is part of that commit
    run_commit(1'b1, 6'd30, 7'b111_0111, 1'b0, '0, '0, 1'b0);

    // Held write stalls through the commit; commit_req mid-commit is ignored
    write_cfg(6'd10, 7'b010_1010, 1'b0);
    run_commit(1'b0, '0, '0, 1'b1, 6'd11, 7'b100_1100, 1'b1);
    run_commit(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);

    // Reset at commit cycle 20 after pad 5 has been copied
    write_cfg(6'd5, 7'b000_0011, 1'b0);
    @(negedge clk);
    commit_req = 1'b1;
    @(negedge clk);
    commit_req = 1'b0;
    repeat (20) @(negedge clk);
    act_m[5] = sh_m[5];
    check_vec("pad5_before_reset", dut_snap, model_snap());
    check_int("busy_before_reset", int'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check_vec("pads_after_reset", dut_snap, model_snap());
    check_int("busy_after_reset", int'(busy), 0);
    check_int("ready_after_reset", int'(cfg_ready), 1);
    seen_done = 1'b0;
    seen_busy = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
      if (busy) seen_busy = 1'b1;
    end
    check_int("no_done_after_reset", int'(seen_done), 0);
    check_int("idle_after_reset", int'(seen_busy), 0);
    check_vec("pads_stay_reset", dut_snap, model_snap());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Overall time bound
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

endmodule
